// File: rtl/bht_update_queue_if.sv
// Fetch/execute side signals of the BHT update queue: prediction pushes, branch
// resolves, the counter-array update strobe and queue status.
interface bht_update_queue_if #(
  parameter int s_index = 5
);
  // push/resolve/flush are single-cycle requests with no ready; the queue accepts
  // or ignores them in the same cycle and reports ignored requests through err.
  logic               push;
  logic [s_index-1:0] push_index;
  logic               push_pred;
  logic               resolve;
  logic               resolve_taken;
  logic               flush;
  logic               branch_res;
  logic [s_index-1:0] windex;
  logic               branch_taken;
  logic               mispredict;
  logic               full;
  logic               empty;
  logic               err;

  modport master (
    output push, push_index, push_pred, resolve, resolve_taken, flush,
    input  branch_res, windex, branch_taken, mispredict, full, empty, err
  );

  modport slave (
    input  push, push_index, push_pred, resolve, resolve_taken, flush,
    output branch_res, windex, branch_taken, mispredict, full, empty, err
  );
endinterface

// File: rtl/bht_update_queue.sv
// In-flight branch queue between fetch predictions and BHT counter updates.
// Optional saturating statistics counters are enabled with BHT_UPDQ_STATS_EN.
module bht_update_queue #(
  parameter int s_index = 5,
  parameter int depth   = 4
) (
  input  logic                clk,
  input  logic                rst_n,
  bht_update_queue_if.slave   bus
`ifdef BHT_UPDQ_STATS_EN
  ,
  output logic [15:0]         resolved_cnt,
  output logic [15:0]         mispred_cnt
`endif
);
  localparam int aw = (depth > 1) ? $clog2(depth) : 1;

  logic [aw-1:0]      head;
  logic [aw-1:0]      tail;
  logic [aw:0]        count;
  logic [s_index-1:0] idx_mem [depth];
  logic [depth-1:0]   pred_mem;

  logic               full_w;
  logic               empty_w;
  logic               accept_res;
  logic               accept_push;
  logic               mispred_now;
  logic               err_set;

  logic               branch_res_q;
  logic [s_index-1:0] windex_q;
  logic               branch_taken_q;
  logic               mispredict_q;
  logic               err_q;

  assign full_w      = (count == (aw+1)'(depth));
  assign empty_w     = (count == '0);
  assign accept_res  = bus.resolve && !empty_w;
  // A full queue still takes a push when the head leaves in the same cycle.
  assign accept_push = bus.push && (!full_w || accept_res);
  assign mispred_now = accept_res && (pred_mem[head] != bus.resolve_taken);
  assign err_set     = (bus.resolve && empty_w) || (bus.push && full_w && !accept_res);

  always_ff @(posedge clk) begin
    if (accept_push && !bus.flush && !mispred_now) begin
      idx_mem[tail]  <= bus.push_index;
      pred_mem[tail] <= bus.push_pred;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      head           <= '0;
      tail           <= '0;
      count          <= '0;
      branch_res_q   <= 1'b0;
      windex_q       <= '0;
      branch_taken_q <= 1'b0;
      mispredict_q   <= 1'b0;
      err_q          <= 1'b0;
    end else if (bus.flush) begin
      head         <= '0;
      tail         <= '0;
      count        <= '0;
      branch_res_q <= 1'b0;
      mispredict_q <= 1'b0;
    end else begin
      branch_res_q <= accept_res;
      mispredict_q <= mispred_now;
      if (accept_res) begin
        windex_q       <= idx_mem[head];
        branch_taken_q <= bus.resolve_taken;
      end
      if (err_set) err_q <= 1'b1;
      // A wrong prediction squashes every younger entry, including one arriving now.
      if (mispred_now) begin
        head  <= '0;
        tail  <= '0;
        count <= '0;
      end else begin
        if (accept_push) tail <= tail + aw'(1);
        if (accept_res)  head <= head + aw'(1);
        case ({accept_push, accept_res})
          2'b10:   count <= count + (aw+1)'(1);
          2'b01:   count <= count - (aw+1)'(1);
          default: count <= count;
        endcase
      end
    end
  end

`ifdef BHT_UPDQ_STATS_EN
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      resolved_cnt <= '0;
      mispred_cnt  <= '0;
    end else if (!bus.flush) begin
      if (accept_res && resolved_cnt != 16'hFFFF) resolved_cnt <= resolved_cnt + 16'd1;
      if (mispred_now && mispred_cnt != 16'hFFFF)  mispred_cnt  <= mispred_cnt + 16'd1;
    end
  end
`endif

  assign bus.branch_res   = branch_res_q;
  assign bus.windex       = windex_q;
  assign bus.branch_taken = branch_taken_q;
  assign bus.mispredict   = mispredict_q;
  assign bus.full         = full_w;
  assign bus.empty        = empty_w;
  assign bus.err          = err_q;
endmodule
